mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Word-organised RAM that sits on the CPU memory bus as the responder.
- Accepts a single-cycle request strobe from the CPU for instruction fetches and load/store accesses.
- After a configurable wait, returns read data or completes a write with a one-cycle data-valid pulse (o_bus_DV). This pulse is what advances the CPU out of FETCH and out of EXECUTE for load/store.
- One outstanding request at a time; no queuing.

Parameters:
- ADDR_WIDTH, 12, word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait cycles inserted between request acceptance and response; legal range 0..15.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  request strobe; sampled only in IDLE.
- i_write  in  1  1 = write, 0 = read; sampled with i_start.
- i_addr  in  32  byte address; sampled with i_start.
- i_wdata  in  32  write data; sampled with i_start.
- i_byte_en  in  4  write byte lanes, bit n = bits 8n+7..8n; ignored for reads.
- o_rdata  out  32  read data; valid while o_bus_DV = 1.
- o_bus_DV  out  1  one-cycle response pulse (read data ready / write done).
- o_busy  out  1  high from acceptance until the DV cycle inclusive.
- o_err  out  1  high only with o_bus_DV when the access was rejected.

Behaviour:
- Reset values: o_bus_DV=0, o_busy=0, o_err=0, o_rdata=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- States:
  - IDLE: if i_start, latch write/addr/wdata/byte_en. Go to WAIT if LATENCY>0, else RESP. o_busy rises next cycle.
  - WAIT: counter runs from LATENCY-1 down to 0; at 0 go to RESP.
  - RESP: o_bus_DV=1 for exactly this cycle; next state IDLE.
- Latency: if i_start is high in cycle N, o_bus_DV is high in cycle N+1+LATENCY.
- Back-to-back requests: i_start in the DV cycle is ignored. The earliest new accept is the cycle after DV, so the minimum request period is LATENCY+2 cycles.
- i_start while busy (WAIT/RESP): ignored and not buffered; latched fields remain unchanged.
- Read:
  - o_rdata = mem[addr[ADDR_WIDTH+1:2]], registered on entry to RESP.
  - o_rdata holds its value after DV until the next read response.
  - Writes leave o_rdata unchanged.
- Write: enabled lanes are written on the edge entering RESP.
  - i_byte_en=0000 is a legal no-op write that still produces DV.
- Error: access is rejected if addr[1:0]!=0 (misaligned) or addr[31:ADDR_WIDTH+2]!=0 (out of range).
  - Rejected access: no RAM write, o_rdata forced to 0, o_err=1 in the DV cycle, DV timing unchanged.
- Reset mid-operation: immediately returns to IDLE with all outputs 0. A pending write that has not yet reached RESP is discarded; no DV is produced for it.
- Read-after-write to the same word: the later read returns the new data.

Optional Feature:
- MEM_RESP_ERR_EN. When defined, error checking is as above.
- When undefined:
  - o_err is tied to 0.
  - addr[1:0] is ignored (access forced to word alignment).
  - Upper address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo depth.
  - Every request completes normally.

Test Plan:
- Reset release, LATENCY=2, read addr 0x0 from preloaded 0x00000013, i_start in cycle 5 -> o_bus_DV=1 only in cycle 8, o_rdata=0x00000013, o_busy high cycles 6-8.
- Write 0xDEADBEEF to 0x40 with byte_en=1111, then byte_en=0010 write 0x0000AA00, then read 0x40 -> o_rdata=0xDEADAAEF, each access gives exactly one DV.
- i_start pulsed every cycle for 10 cycles with LATENCY=2 -> exactly 3 DV pulses, at cycles N+3, N+7, N+11 relative to the first accept N.
- Read 0x42 (misaligned) and read 0x4000 with ADDR_WIDTH=12 -> with MEM_RESP_ERR_EN: o_err=1, o_rdata=0, mem unchanged; without: read 0x42 returns mem[0x40], read 0x4000 returns mem[0x0], o_err=0.
- Write 0x12345678 to 0x80, assert i_rst_n=0 in the WAIT cycle -> outputs 0 asynchronously, no DV; subsequent read of 0x80 returns the prior contents.
- LATENCY=0: i_start in cycle N -> DV in cycle N+1; a second i_start in cycle N+1 is ignored, a third in N+2 gives DV at N+3.

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: word-organised RAM responding to single-cycle CPU bus requests after LATENCY wait cycles.
// Optional macro MEM_RESP_ERR_EN enables rejection of misaligned and out-of-range accesses.
module mem_bus_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_write,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_byte_en,
   output logic [31:0] o_rdata,
   output logic        o_bus_DV,
   output logic        o_busy,
   output logic        o_err
);
   localparam int         DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nxt;
   logic                  r_write;
   logic [31:0]           r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_byte_en;
   logic [31:0]           r_rdata;
   logic                  r_dv;
   logic                  r_busy;
   logic                  r_err;
   logic [31:0]           r_mem [DEPTH];
   logic                  w_accept;
   logic                  w_enter_resp;
   logic                  w_write;
   logic                  w_err;
   logic                  w_mem_we;
   logic [31:0]           w_addr;
   logic [31:0]           w_wdata;
   logic [3:0]            w_byte_en;
   logic [ADDR_WIDTH-1:0] w_idx;

   assign w_accept = (r_state == S_IDLE) && i_start;

   // With LATENCY=0 RESP is entered on the accept edge itself, before the request is latched.
   assign w_write   = (r_state == S_IDLE) ? i_write   : r_write;
   assign w_addr    = (r_state == S_IDLE) ? i_addr    : r_addr;
   assign w_wdata   = (r_state == S_IDLE) ? i_wdata   : r_wdata;
   assign w_byte_en = (r_state == S_IDLE) ? i_byte_en : r_byte_en;
   assign w_idx     = w_addr[ADDR_WIDTH+1:2];

`ifdef MEM_RESP_ERR_EN
   assign w_err = (w_addr[1:0] != 2'b00) ||
                  (w_addr[31:ADDR_WIDTH+2] != {(30 - ADDR_WIDTH){1'b0}});
`else
   logic w_unused_addr;
   assign w_unused_addr = ^{w_addr[31:ADDR_WIDTH+2], w_addr[1:0]};
   assign w_err         = 1'b0;
`endif

   assign w_enter_resp = (w_state_nxt == S_RESP);
   assign w_mem_we     = i_rst_n && w_enter_resp && w_write && !w_err;

   // Next-state and wait-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (LATENCY > 0) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_LOAD;
               end else begin
                  w_state_nxt = S_RESP;
                  w_cnt_nxt   = 4'd0;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, counter and registered response outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_dv    <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'h0000_0000;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dv    <= w_enter_resp;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_err   <= w_enter_resp && w_err;
         if (w_enter_resp && (w_err || !w_write)) begin
            r_rdata <= w_err ? 32'h0000_0000 : r_mem[w_idx];
         end
      end
   end

   // Request capture; fields change only on an accepted strobe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_write   <= 1'b0;
         r_addr    <= 32'h0000_0000;
         r_wdata   <= 32'h0000_0000;
         r_byte_en <= 4'h0;
      end else if (w_accept) begin
         r_write   <= i_write;
         r_addr    <= i_addr;
         r_wdata   <= i_wdata;
         r_byte_en <= i_byte_en;
      end
   end

   // RAM byte-lane write on the edge entering RESP; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_byte_en[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata  = r_rdata;
   assign o_bus_DV = r_dv;
   assign o_busy   = r_busy;
   assign o_err    = r_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: table-driven accesses through a scoreboard
// plus hand-written timing, back-to-back, reset-abort and zero-latency sequences.
module tb_mem_bus_responder;
   localparam int LAT = 2;
`ifdef MEM_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic        rd;
      logic [31:0] rdata;
      logic        err;
   } sb_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, write;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        dv, busy, err;
   logic        z_start, z_write;
   logic [31:0] z_addr, z_wdata;
   logic [3:0]  z_be;
   logic [31:0] z_rdata;
   logic        z_dv, z_busy, z_err;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   dv_cnt = 0;
   sb_t  sb[$];
   sb_t  mon_e;
   vec_t tbl[16];

   mem_bus_responder #(.ADDR_WIDTH(12), .LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_write(write), .i_addr(addr),
      .i_wdata(wdata), .i_byte_en(be), .o_rdata(rdata), .o_bus_DV(dv), .o_busy(busy), .o_err(err)
   );

   mem_bus_responder #(.ADDR_WIDTH(12), .LATENCY(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(z_start), .i_write(z_write), .i_addr(z_addr),
      .i_wdata(z_wdata), .i_byte_en(z_be), .o_rdata(z_rdata), .o_bus_DV(z_dv), .o_busy(z_busy),
      .o_err(z_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Response monitor: every DV pulse must match the oldest scoreboard entry.
   always @(negedge clk) begin
      if (dv === 1'b1) begin
         dv_cnt = dv_cnt + 1;
         if (sb.size() == 0) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL dv_unexpected: got DV at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("dv_cycle", cyc, mon_e.cyc);
            chk("err", {31'd0, err}, {31'd0, mon_e.err});
            if (mon_e.rd || mon_e.err) chk("rdata", rdata, mon_e.rdata);
         end
      end
   end

   task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input logic [31:0] er, input logic ee);
      sb_t e;
      start = 1'b1; write = wr; addr = a; wdata = wd; be = b;
      e.cyc = cyc + 1 + LAT; e.rd = !wr; e.rdata = er; e.err = ee;
      sb.push_back(e);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 64) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", sb.size(), 32'd0);
      sb.delete();
   endtask

   task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] b, input logic [31:0] er, input logic ee);
      @(negedge clk);
      drive(wr, a, wd, b, er, ee);
      @(negedge clk);
      start = 1'b0;
      drain();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int          n0;
      int          base;
      logic [31:0] exp80;

      rst_n = 1'b1; start = 1'b0; write = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
      z_start = 1'b0; z_write = 1'b0; z_addr = 32'd0; z_wdata = 32'd0; z_be = 4'd0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dv", {31'd0, dv}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Preload word 0, then a read with cycle-exact busy/DV tracking.
      run_txn(1'b1, 32'h0, 32'h0000_0013, 4'hF, 32'd0, 1'b0);
      @(negedge clk);
      n0 = cyc;
      drive(1'b0, 32'h0, 32'd0, 4'h0, 32'h0000_0013, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         chk($sformatf("busy_n%0d", k), {31'd0, busy}, {31'd0, (k <= 3)});
      end
      drain();

      // Strobe held for 10 cycles: accepts at n0, n0+4, n0+8 only.
      @(negedge clk);
      n0   = cyc;
      base = dv_cnt;
      start = 1'b1; write = 1'b0; addr = 32'h0;
      for (int k = 0; k < 3; k++) sb.push_back('{n0 + 3 + 4 * k, 1'b1, 32'h0000_0013, 1'b0});
      repeat (10) @(negedge clk);
      start = 1'b0;
      drain();
      chk("b2b_dv_count", dv_cnt - base, 32'd3);

      tbl[0]  = '{1'b1, 32'h40,   32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
      tbl[1]  = '{1'b1, 32'h40,   32'h0000_AA00, 4'h2, 32'h0, 1'b0};
      tbl[2]  = '{1'b0, 32'h40,   32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
      tbl[3]  = '{1'b1, 32'h44,   32'h1122_3344, 4'hF, 32'h0, 1'b0};
      tbl[4]  = '{1'b1, 32'h44,   32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
      tbl[5]  = '{1'b0, 32'h44,   32'h0,         4'h0, 32'h1122_3344, 1'b0};
      tbl[6]  = '{1'b1, 32'h48,   32'h0,         4'hF, 32'h0, 1'b0};
      tbl[7]  = '{1'b1, 32'h48,   32'hAABB_CCDD, 4'h9, 32'h0, 1'b0};
      tbl[8]  = '{1'b0, 32'h48,   32'h0,         4'h0, 32'hAA00_00DD, 1'b0};
      tbl[9]  = '{1'b0, 32'h42,   32'h0,         4'h0, ERR_EN ? 32'h0 : 32'hDEAD_AAEF, ERR_EN};
      tbl[10] = '{1'b0, 32'h4000, 32'h0,         4'h0, ERR_EN ? 32'h0 : 32'h0000_0013, ERR_EN};
      tbl[11] = '{1'b1, 32'h42,   32'h9999_9999, 4'hF, 32'h0, ERR_EN};
      tbl[12] = '{1'b0, 32'h40,   32'h0,         4'h0, ERR_EN ? 32'hDEAD_AAEF : 32'h9999_9999, 1'b0};
      tbl[13] = '{1'b1, 32'h80,   32'h0BAD_F00D, 4'hF, 32'h0, 1'b0};
      tbl[14] = '{1'b1, 32'h4080, 32'h5555_AAAA, 4'hF, 32'h0, ERR_EN};
      tbl[15] = '{1'b0, 32'h80,   32'h0,         4'h0, ERR_EN ? 32'h0BAD_F00D : 32'h5555_AAAA, 1'b0};
      exp80   = ERR_EN ? 32'h0BAD_F00D : 32'h5555_AAAA;
      for (int i = 0; i < 16; i++) begin
         base = dv_cnt;
         run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp_rdata, tbl[i].exp_err);
         chk($sformatf("tbl%0d_one_dv", i), dv_cnt - base, 32'd1);
      end

      // Reset during WAIT discards the pending write and its DV.
      @(negedge clk);
      start = 1'b1; write = 1'b1; addr = 32'h80; wdata = 32'h1234_5678; be = 4'hF;
      @(negedge clk);
      start = 1'b0;
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      base = dv_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_dv", {31'd0, dv}, 32'd0);
      chk("abort_err", {31'd0, err}, 32'd0);
      chk("abort_rdata", rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_dv", dv_cnt - base, 32'd0);
      run_txn(1'b0, 32'h80, 32'h0, 4'h0, exp80, 1'b0);

      // Zero-latency instance: DV next cycle, strobe in the DV cycle ignored.
      @(negedge clk);
      z_start = 1'b1; z_write = 1'b1; z_addr = 32'h0; z_wdata = 32'h0000_0077; z_be = 4'hF;
      @(negedge clk);
      chk("z_dv_n1", {31'd0, z_dv}, 32'd1);
      chk("z_busy_n1", {31'd0, z_busy}, 32'd1);
      z_wdata = 32'h0000_0088;
      @(negedge clk);
      chk("z_dv_n2", {31'd0, z_dv}, 32'd0);
      chk("z_busy_n2", {31'd0, z_busy}, 32'd0);
      z_write = 1'b0;
      @(negedge clk);
      chk("z_dv_n3", {31'd0, z_dv}, 32'd1);
      chk("z_rdata_n3", z_rdata, 32'h0000_0077);
      chk("z_err_n3", {31'd0, z_err}, 32'd0);
      z_start = 1'b0;
      @(negedge clk);
      chk("z_dv_n4", {31'd0, z_dv}, 32'd0);
      chk("z_rdata_hold", z_rdata, 32'h0000_0077);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
